tow_match: RTL and testbench

Parametrised tug-of-war match controller: the successor to the fixed seven-LED game top.
- Generalises track length, reaction-delay range and tick rate.
- Adds false-start penalties, a GO-phase timeout and explicit match-over/winner reporting.
- Sits between the pushbutton synchronizers and the LED/display drivers. Owns the round state machine, random delay, arbitration and marker position.

---
 rtl/tow_pkg.sv | 29 ++
 rtl/tow_lfsr.sv | 27 ++
 rtl/tow_match.sv | 236 +++++++++++++++++++++++
 tb/tb_tow_match.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war match controller.
package tow_pkg;

    // Round state machine encoding.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        GO   = 3'd2,
        SHOW = 3'd3,
        DONE = 3'd4
    } tow_state_e;

    // Winner report codes.
    typedef enum logic [1:0] {
        WIN_NONE  = 2'b00,
        WIN_LEFT  = 2'b01,
        WIN_RIGHT = 2'b10
    } tow_winner_e;

    // 16-bit LFSR seed and feedback taps (bits 16,14,13,11 in 1-based numbering).
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One Fibonacci step: shift left, feed back the XOR parity of the tapped bits.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        lfsr_next = {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/tow_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; exposes its low OUT_W bits.
module tow_lfsr
    import tow_pkg::*;
#(
    parameter int OUT_W = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    output logic [OUT_W-1:0] value
);

    logic [15:0] value_r;

    // Advance every clock; an all-zero state (unreachable from the seed) is forced back to the seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r <= LFSR_SEED;
        end else if (value_r == 16'h0000) begin
            value_r <= LFSR_SEED;
        end else begin
            value_r <= lfsr_next(value_r);
        end
    end

    assign value = value_r[OUT_W-1:0];

endmodule

// File: rtl/tow_match.sv
// Tug-of-war match controller: round FSM, random delay, arbitration and marker position.
module tow_match
    import tow_pkg::*;
#(
    parameter int TRACK_LEN   = 7,
    parameter int WAIT_W      = 8,
    parameter int PRESCALE    = 256,
    parameter int GO_TIMEOUT  = 64,
    parameter int FLASH_TICKS = 16,
    parameter int PENALTY     = 1
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pbl,
    input  logic                 pbr,
    output logic [TRACK_LEN-1:0] track,
    output logic                 go_led,
    output logic                 flash,
    output logic                 false_start,
    output logic [1:0]           winner,
    output logic                 match_over
);

    localparam int POS_W   = $clog2(TRACK_LEN);
    localparam int PS_W    = $clog2(PRESCALE);
    localparam int TMR_MAX = (GO_TIMEOUT > FLASH_TICKS) ? GO_TIMEOUT : FLASH_TICKS;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int CNT_W   = (TMR_W > WAIT_W) ? TMR_W : WAIT_W;

    localparam logic [POS_W-1:0]     POS_C      = POS_W'((TRACK_LEN - 1) / 2);
    localparam logic [POS_W-1:0]     POS_MAX    = POS_W'(TRACK_LEN - 1);
    localparam logic [POS_W-1:0]     POS_ZERO   = {POS_W{1'b0}};
    localparam logic [POS_W-1:0]     POS_ONE    = POS_W'(1);
    localparam logic [PS_W-1:0]      PS_LAST    = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]      PS_ONE     = PS_W'(1);
    localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]     GO_LOAD    = CNT_W'(GO_TIMEOUT);
    localparam logic [CNT_W-1:0]     FLASH_LOAD = CNT_W'(FLASH_TICKS);
    localparam logic [TRACK_LEN-1:0] TRACK_LSB  = {{(TRACK_LEN-1){1'b0}}, 1'b1};

    tow_state_e         state_r, state_s;
    tow_winner_e        winner_r, winner_s;
    logic [POS_W-1:0]   pos_r, pos_s, pos_up_s, pos_dn_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s, delay_load_s;
    logic [PS_W-1:0]    ps_r;
    logic               tick_s;
    logic               pbl_q_r, pbr_q_r;
    logic               l_edge_s, r_edge_s;
    logic               fs_s;
    logic [WAIT_W-2:0]  lfsr_s;
    logic [TRACK_LEN-1:0] track_r;
    logic               go_led_r, flash_r, false_start_r, match_over_r;

    tow_lfsr #(
        .OUT_W (WAIT_W - 1)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst),
        .value (lfsr_s)
    );

    assign tick_s       = (ps_r == PS_LAST);
    assign l_edge_s     = pbl & ~pbl_q_r;
    assign r_edge_s     = pbr & ~pbr_q_r;
    assign delay_load_s = CNT_W'({1'b1, lfsr_s});
    assign pos_up_s     = (pos_r == POS_MAX)  ? pos_r : pos_r + POS_ONE;
    assign pos_dn_s     = (pos_r == POS_ZERO) ? pos_r : pos_r - POS_ONE;

    // Free-running prescaler; tick_s marks the last clock of each period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_r <= {PS_W{1'b0}};
        end else if (tick_s) begin
            ps_r <= {PS_W{1'b0}};
        end else begin
            ps_r <= ps_r + PS_ONE;
        end
    end

    // Previous button levels, so a button held across a state change yields no new edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pbl_q_r <= 1'b0;
            pbr_q_r <= 1'b0;
        end else begin
            pbl_q_r <= pbl;
            pbr_q_r <= pbr;
        end
    end

    // Next-state logic: counter loads take priority over a coincident tick decrement.
    always_comb begin
        state_s  = state_r;
        pos_s    = pos_r;
        cnt_s    = cnt_r;
        winner_s = winner_r;
        fs_s     = 1'b0;
        case (state_r)
            IDLE: begin
                pos_s    = POS_C;
                winner_s = WIN_NONE;
                if (start) begin
                    state_s = WAIT;
                    cnt_s   = delay_load_s;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (l_edge_s || r_edge_s) begin
                    fs_s = 1'b1;
                    if (l_edge_s && r_edge_s) begin
                        cnt_s = delay_load_s;
                    end else if (PENALTY == 1) begin
                        // A single false start hands the point to the opponent and shows it.
                        state_s = SHOW;
                        cnt_s   = FLASH_LOAD;
                        pos_s   = l_edge_s ? pos_up_s : pos_dn_s;
                    end else begin
                        cnt_s = delay_load_s;
                    end
                end else if (tick_s) begin
                    if (cnt_r <= CNT_ONE) begin
                        state_s = GO;
                        cnt_s   = GO_LOAD;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            GO: begin
                // A press beats a timeout tick arriving in the same cycle.
                if (l_edge_s || r_edge_s) begin
                    state_s = SHOW;
                    cnt_s   = FLASH_LOAD;
                    if (l_edge_s && r_edge_s) begin
                        pos_s = pos_r;
                    end else if (l_edge_s) begin
                        pos_s = pos_dn_s;
                    end else begin
                        pos_s = pos_up_s;
                    end
                end else if (tick_s) begin
                    if (cnt_r <= CNT_ONE) begin
                        state_s = SHOW;
                        cnt_s   = FLASH_LOAD;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            SHOW: begin
                if (tick_s) begin
                    if (cnt_r <= CNT_ONE) begin
                        if (pos_r == POS_ZERO) begin
                            state_s  = DONE;
                            winner_s = WIN_LEFT;
                        end else if (pos_r == POS_MAX) begin
                            state_s  = DONE;
                            winner_s = WIN_RIGHT;
                        end else begin
                            state_s = WAIT;
                            cnt_s   = delay_load_s;
                        end
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            DONE: begin
                // Restart folds the IDLE actions into this transition.
                if (start) begin
                    state_s  = WAIT;
                    pos_s    = POS_C;
                    winner_s = WIN_NONE;
                    cnt_s    = delay_load_s;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s  = IDLE;
                pos_s    = POS_C;
                winner_s = WIN_NONE;
                cnt_s    = {CNT_W{1'b0}};
            end
        endcase
    end

    // Round state, marker position and shared delay/timeout/flash counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            pos_r    <= POS_C;
            cnt_r    <= {CNT_W{1'b0}};
            winner_r <= WIN_NONE;
        end else begin
            state_r  <= state_s;
            pos_r    <= pos_s;
            cnt_r    <= cnt_s;
            winner_r <= winner_s;
        end
    end

    // Registered outputs decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            track_r       <= TRACK_LSB << POS_C;
            go_led_r      <= 1'b0;
            flash_r       <= 1'b0;
            false_start_r <= 1'b0;
            match_over_r  <= 1'b0;
        end else begin
            track_r       <= TRACK_LSB << pos_s;
            go_led_r      <= (state_s == GO);
            flash_r       <= (state_s == SHOW);
            false_start_r <= fs_s;
            match_over_r  <= (state_s == DONE);
        end
    end

    assign track       = track_r;
    assign go_led      = go_led_r;
    assign flash       = flash_r;
    assign false_start = false_start_r;
    assign winner      = winner_r;
    assign match_over  = match_over_r;

endmodule

// File: tb/tb_tow_match.sv
// Randomized self-checking bench for tow_match against a round-level reference model.
module tb_tow_match;

    localparam int TRACK_LEN   = 7;
    localparam int WAIT_W      = 4;
    localparam int PRESCALE    = 4;
    localparam int GO_TIMEOUT  = 8;
    localparam int FLASH_TICKS = 2;
    localparam int CENTRE      = (TRACK_LEN - 1) / 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, pbl = 1'b0, pbr = 1'b0;
    logic [TRACK_LEN-1:0] track;
    logic go_led, flash, false_start, match_over;
    logic [1:0] winner;
    logic start_np = 1'b0, pbl_np = 1'b0, pbr_np = 1'b0;
    logic [TRACK_LEN-1:0] track_np;
    logic go_led_np, flash_np, false_start_np, match_over_np;
    logic [1:0] winner_np;

    int total = 0;
    int bad = 0;
    int edge_cnt;
    logic [15:0] m_lfsr;
    int m_pos = CENTRE;
    int go_edge = 0;

    tow_match #(.TRACK_LEN(TRACK_LEN), .WAIT_W(WAIT_W), .PRESCALE(PRESCALE),
                .GO_TIMEOUT(GO_TIMEOUT), .FLASH_TICKS(FLASH_TICKS), .PENALTY(1)) dut (
        .clk(clk), .rst(rst), .start(start), .pbl(pbl), .pbr(pbr), .track(track),
        .go_led(go_led), .flash(flash), .false_start(false_start), .winner(winner),
        .match_over(match_over));

    tow_match #(.TRACK_LEN(TRACK_LEN), .WAIT_W(WAIT_W), .PRESCALE(PRESCALE),
                .GO_TIMEOUT(GO_TIMEOUT), .FLASH_TICKS(FLASH_TICKS), .PENALTY(0)) dut_np (
        .clk(clk), .rst(rst), .start(start_np), .pbl(pbl_np), .pbr(pbr_np), .track(track_np),
        .go_led(go_led_np), .flash(flash_np), .false_start(false_start_np), .winner(winner_np),
        .match_over(match_over_np));

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_ref(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Edge counter since reset release and reference LFSR.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= 0;
            m_lfsr   <= 16'hACE1;
        end else begin
            edge_cnt <= edge_cnt + 1;
            m_lfsr   <= lfsr_ref(m_lfsr);
        end
    end

    // Delay d ticks loaded at edge e expires on the d-th tick edge after e; ticks land on multiples of PRESCALE.
    function automatic int calc_go(input int e, input logic [15:0] lf);
        int half;
        int d;
        half = 1 << (WAIT_W - 1);
        d = half + (int'(lf) % half);
        return (e / PRESCALE + d) * PRESCALE;
    endfunction

    function automatic int sat(input int p);
        if (p < 0) return 0;
        if (p > TRACK_LEN - 1) return TRACK_LEN - 1;
        return p;
    endfunction

    function automatic logic [31:0] exp_track();
        return 32'd1 << m_pos;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int t);
        while (edge_cnt < t) step();
    endtask

    task automatic press(input logic l, input logic r, output logic [15:0] lf);
        pbl = l;
        pbr = r;
        lf = m_lfsr;
        step();
        pbl = 1'b0;
        pbr = 1'b0;
    endtask

    // kind: 0 right in GO, 1 left in GO, 2 both in GO, 3 timeout,
    //       4 left false start, 5 right false start, 6 both in WAIT then right in GO.
    task automatic play_round(input int kind, input int ofs);
        int f;
        int p;
        int s;
        int e;
        logic [15:0] lf;
        p = 0;
        if (kind >= 4) begin
            f = edge_cnt + 1 + (ofs % (go_edge - edge_cnt - 1));
            step_to(f - 1);
            press(kind == 4 || kind == 6, kind == 5 || kind == 6, lf);
            check_eq("fs_pulse", false_start, 1);
            check_eq("fs_go_low", go_led, 0);
            if (kind == 6) begin
                check_eq("fs_both_pos", track, exp_track());
                check_eq("fs_both_noshow", flash, 0);
                go_edge = calc_go(f, lf);
            end else begin
                m_pos = (kind == 4) ? sat(m_pos + 1) : sat(m_pos - 1);
                check_eq("fs_pos", track, exp_track());
                check_eq("fs_show", flash, 1);
                p = f;
            end
            step();
            check_eq("fs_width", false_start, 0);
        end
        if (kind < 4 || kind == 6) begin
            if ((ofs & 1) != 0) begin
                step_to(go_edge - 3);
                start = 1'b1;
                step();
                start = 1'b0;
            end
            step_to(go_edge - 1);
            check_eq("go_early", go_led, 0);
            step();
            check_eq("go_rise", go_led, 1);
            if (kind == 3) begin
                p = go_edge + GO_TIMEOUT * PRESCALE;
                step_to(p - 1);
                check_eq("to_hold", go_led, 1);
                step();
                check_eq("to_fall", go_led, 0);
                check_eq("to_show", flash, 1);
                check_eq("to_pos", track, exp_track());
            end else begin
                p = go_edge + 1 + (ofs % (GO_TIMEOUT * PRESCALE));
                step_to(p - 1);
                press(kind == 1 || kind == 2, kind == 0 || kind == 2 || kind == 6, lf);
                if (kind == 0 || kind == 6) m_pos = sat(m_pos + 1);
                if (kind == 1) m_pos = sat(m_pos - 1);
                check_eq("score_pos", track, exp_track());
                check_eq("score_go_low", go_led, 0);
                check_eq("score_show", flash, 1);
            end
        end
        s = (p / PRESCALE + FLASH_TICKS) * PRESCALE;
        step_to(s - 1);
        check_eq("flash_hold", flash, 1);
        lf = m_lfsr;
        step();
        check_eq("flash_end", flash, 0);
        if (m_pos == 0 || m_pos == TRACK_LEN - 1) begin
            check_eq("done_over", match_over, 1);
            check_eq("done_winner", winner, (m_pos == 0) ? 1 : 2);
            repeat (1 + ofs % 4) step();
            check_eq("done_hold_over", match_over, 1);
            check_eq("done_hold_winner", winner, (m_pos == 0) ? 1 : 2);
            check_eq("done_hold_track", track, exp_track());
            lf = m_lfsr;
            e = edge_cnt + 1;
            start = 1'b1;
            step();
            start = 1'b0;
            m_pos = CENTRE;
            check_eq("restart_track", track, exp_track());
            check_eq("restart_winner", winner, 0);
            check_eq("restart_over", match_over, 0);
            go_edge = calc_go(e, lf);
        end else begin
            check_eq("show_not_over", match_over, 0);
            check_eq("show_pos", track, exp_track());
            go_edge = calc_go(s, lf);
        end
    endtask

    initial begin
        int e;
        int f;
        int gnp;
        logic [15:0] lf;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        check_eq("rst_track", track, 32'h08);
        check_eq("rst_winner", winner, 0);
        check_eq("rst_go", go_led, 0);
        check_eq("rst_flash", flash, 0);
        check_eq("rst_fs", false_start, 0);
        check_eq("rst_over", match_over, 0);
        step();
        check_eq("lfsr_first", dut.u_lfsr.value_r, m_lfsr);

        // PENALTY=0 instance: a single false start only reloads the delay.
        lf = m_lfsr;
        e = edge_cnt + 1;
        start_np = 1'b1;
        step();
        start_np = 1'b0;
        gnp = calc_go(e, lf);
        f = e + 3;
        step_to(f - 1);
        pbl_np = 1'b1;
        lf = m_lfsr;
        step();
        pbl_np = 1'b0;
        check_eq("np_fs_pulse", false_start_np, 1);
        check_eq("np_pos", track_np, 32'h08);
        check_eq("np_noshow", flash_np, 0);
        check_eq("np_winner", winner_np, 0);
        check_eq("np_over", match_over_np, 0);
        step();
        check_eq("np_fs_width", false_start_np, 0);
        gnp = calc_go(f, lf);
        step_to(gnp - 1);
        check_eq("np_go_early", go_led_np, 0);
        step();
        check_eq("np_go_reload", go_led_np, 1);

        check_eq("idle_track", track, 32'h08);
        check_eq("idle_go", go_led, 0);
        lf = m_lfsr;
        e = edge_cnt + 1;
        start = 1'b1;
        step();
        start = 1'b0;
        go_edge = calc_go(e, lf);
        check_eq("start_go_low", go_led, 0);

        play_round(0, 3);
        play_round(0, 10);
        play_round(0, 31);
        play_round(4, 5);
        play_round(2, 7);
        play_round(6, 2);
        play_round(3, 0);
        play_round(1, 0);
        for (int i = 0; i < 40; i++) begin
            play_round(int'($urandom_range(0, 6)), int'($urandom_range(0, 1000)));
        end

        // Reset in the middle of GO returns every output to its reset value at once.
        step_to(go_edge + 2);
        check_eq("pre_rst_go", go_led, 1);
        #2 rst = 1'b0;
        #1;
        check_eq("mid_rst_track", track, 32'h08);
        check_eq("mid_rst_go", go_led, 0);
        check_eq("mid_rst_flash", flash, 0);
        check_eq("mid_rst_fs", false_start, 0);
        check_eq("mid_rst_winner", winner, 0);
        check_eq("mid_rst_over", match_over, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        m_pos = CENTRE;
        repeat (3) step();
        check_eq("post_rst_go", go_led, 0);
        check_eq("post_rst_track", track, exp_track());
        check_eq("post_rst_lfsr", dut.u_lfsr.value_r, m_lfsr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
